aq_ifu_ras_stack: RTL and testbench

AQ_IFU_RAS_STACK -- requirements
Module: aq_ifu_ras_stack

---
 rtl/aq_ifu_ras_stack_pkg.sv | 32 +++
 rtl/aq_ifu_ras_pentry.sv | 41 ++++
 rtl/gated_clk_cell.sv | 26 ++
 rtl/aq_ifu_ras_stack.sv | 126 ++++++++++++
 tb/tb_aq_ifu_ras_stack.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/aq_ifu_ras_stack_pkg.sv
// Shared IFU return-address-stack definitions: default sizing, pointer-width
// derivation and the decoded stack operation used by the top and its tests.
package aq_ifu_ras_stack_pkg;

    localparam int RAS_DEPTH_DEF = 8;
    localparam int RAS_PC_W_DEF  = 24;

    typedef enum logic [1:0] {
        RAS_OP_NONE,
        RAS_OP_PUSH,
        RAS_OP_POP,
        RAS_OP_REPL
    } ras_op_e;

    function automatic int ras_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // A push+pop pair on a non-empty stack replaces the top in place; on an
    // empty stack the pop has nothing to remove, so only the push survives.
    function automatic ras_op_e ras_op_decode(input logic push,
                                              input logic pop,
                                              input logic nonempty);
        ras_op_e op;
        op = RAS_OP_NONE;
        if (push && pop && nonempty) op = RAS_OP_REPL;
        else if (push)               op = RAS_OP_PUSH;
        else if (pop && nonempty)    op = RAS_OP_POP;
        return op;
    endfunction

endpackage

// File: rtl/aq_ifu_ras_pentry.sv
// One return-address entry: its own clock gate plus a PC register that is
// written only on the cycle the stack selects this entry.
import aq_ifu_ras_stack_pkg::*;

module aq_ifu_ras_pentry #(
    parameter int PC_W = RAS_PC_W_DEF
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            cp0_yy_clk_en,
    input  logic            cp0_ifu_icg_en,
    input  logic            pad_yy_icg_scan_en,
    input  logic            i_wen,
    input  logic [PC_W-1:0] i_wdata,
    output logic [PC_W-1:0] o_pc
);

    logic            w_entry_clk;
    logic [PC_W-1:0] r_pc;

    gated_clk_cell x_entry_gateclk (
        .clk_in             (forever_cpuclk),
        .global_en          (cp0_yy_clk_en),
        .module_en          (cp0_ifu_icg_en),
        .local_en           (i_wen),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (w_entry_clk)
    );

    // NOTE: entries are reset so a prediction from a never-written slot is a
    // deterministic 0; the write enable stays in the register because the
    // gate can be forced open by module enable or scan.
    always_ff @(posedge w_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b)  r_pc <= '0;
        else if (i_wen) r_pc <= i_wdata;
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/gated_clk_cell.sv
// Behavioural integrated clock-gate: enable captured by a low-transparent
// latch so the gated clock never glitches; scan enable forces the clock on.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic w_clk_en_bf_latch;
    logic r_clk_en;

    assign w_clk_en_bf_latch = (global_en && (module_en || local_en)) || external_en;

    // NOTE: this latch is intentional -- it holds the enable stable while the
    // clock is high; everywhere else combinational logic must not infer one.
    always_latch begin
        if (!clk_in) r_clk_en <= w_clk_en_bf_latch || pad_yy_icg_scan_en;
    end

    assign clk_out = clk_in & r_clk_en;

endmodule

// File: rtl/aq_ifu_ras_stack.sv
// Return address stack: speculative and committed pointer/count pairs over a
// circular array of gated entries; flush restores speculative from committed.
import aq_ifu_ras_stack_pkg::*;

module aq_ifu_ras_stack #(
    parameter int DEPTH = RAS_DEPTH_DEF,
    parameter int PC_W  = RAS_PC_W_DEF
) (
    input  logic            forever_cpuclk,
    input  logic            cpurst_b,
    input  logic            cp0_yy_clk_en,
    input  logic            cp0_ifu_icg_en,
    input  logic            pad_yy_icg_scan_en,
    input  logic            ras_push,
    input  logic [PC_W-1:0] ras_push_pc,
    input  logic            ras_pop,
    input  logic            ras_cmt_push,
    input  logic            ras_cmt_pop,
    input  logic            ras_flush,
    output logic [PC_W-1:0] ras_top_pc,
    output logic            ras_top_vld,
    output logic            ras_full
);

    localparam int PTR_W = ras_ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_spec_tp;
    logic [CNT_W-1:0] r_spec_cnt;
    logic [PTR_W-1:0] r_cmt_tp;
    logic [CNT_W-1:0] r_cmt_cnt;

    ras_op_e          w_spec_op;
    ras_op_e          w_cmt_op;
    logic [PTR_W-1:0] w_spec_tp_inc;
    logic [PTR_W-1:0] w_spec_tp_nxt;
    logic [CNT_W-1:0] w_spec_cnt_nxt;
    logic [PTR_W-1:0] w_cmt_tp_nxt;
    logic [CNT_W-1:0] w_cmt_cnt_nxt;
    logic [DEPTH-1:0] w_entry_wen;
    logic [PC_W-1:0]  w_entry_pc [DEPTH];

    // Pointer/count update shared by the speculative and committed views;
    // a push into a full stack wraps over the oldest entry and stays full.
    function automatic logic [PTR_W+CNT_W-1:0] ras_step(input ras_op_e          op,
                                                        input logic [PTR_W-1:0] tp,
                                                        input logic [CNT_W-1:0] cnt);
        logic [PTR_W-1:0] tp_n;
        logic [CNT_W-1:0] cnt_n;
        tp_n  = tp;
        cnt_n = cnt;
        case (op)
            RAS_OP_PUSH: begin
                tp_n  = tp + PTR_W'(1);
                cnt_n = (cnt == CNT_FULL) ? cnt : cnt + CNT_W'(1);
            end
            RAS_OP_POP: begin
                tp_n  = tp - PTR_W'(1);
                cnt_n = cnt - CNT_W'(1);
            end
            default: ;
        endcase
        return {tp_n, cnt_n};
    endfunction

    assign w_spec_op     = ras_op_decode(ras_push, ras_pop, r_spec_cnt != '0);
    assign w_cmt_op      = ras_op_decode(ras_cmt_push, ras_cmt_pop, r_cmt_cnt != '0);
    assign w_spec_tp_inc = r_spec_tp + PTR_W'(1);

    always_comb begin
        {w_cmt_tp_nxt, w_cmt_cnt_nxt} = ras_step(w_cmt_op, r_cmt_tp, r_cmt_cnt);
        if (ras_flush) begin
            w_spec_tp_nxt  = w_cmt_tp_nxt;
            w_spec_cnt_nxt = w_cmt_cnt_nxt;
        end else begin
            {w_spec_tp_nxt, w_spec_cnt_nxt} = ras_step(w_spec_op, r_spec_tp, r_spec_cnt);
        end
    end

    // Flush wins over the same-cycle speculative push, so no entry is written.
    always_comb begin
        w_entry_wen = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_entry_wen[i] = !ras_flush &&
                             (((w_spec_op == RAS_OP_PUSH) && (w_spec_tp_inc == PTR_W'(i))) ||
                              ((w_spec_op == RAS_OP_REPL) && (r_spec_tp     == PTR_W'(i))));
        end
    end

    // NOTE: state registers use non-blocking assignment so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_spec_tp  <= PTR_W'(DEPTH - 1);
            r_spec_cnt <= '0;
            r_cmt_tp   <= PTR_W'(DEPTH - 1);
            r_cmt_cnt  <= '0;
        end else begin
            r_spec_tp  <= w_spec_tp_nxt;
            r_spec_cnt <= w_spec_cnt_nxt;
            r_cmt_tp   <= w_cmt_tp_nxt;
            r_cmt_cnt  <= w_cmt_cnt_nxt;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        aq_ifu_ras_pentry #(
            .PC_W (PC_W)
        ) x_ras_pentry (
            .forever_cpuclk     (forever_cpuclk),
            .cpurst_b           (cpurst_b),
            .cp0_yy_clk_en      (cp0_yy_clk_en),
            .cp0_ifu_icg_en     (cp0_ifu_icg_en),
            .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
            .i_wen              (w_entry_wen[g]),
            .i_wdata            (ras_push_pc),
            .o_pc               (w_entry_pc[g])
        );
    end

    assign ras_top_pc  = w_entry_pc[r_spec_tp];
    assign ras_top_vld = (r_spec_cnt != '0);
    assign ras_full    = (r_spec_cnt == CNT_FULL);

endmodule

// File: tb/tb_aq_ifu_ras_stack.sv
// Directed bench for aq_ifu_ras_stack (DEPTH=8, PC_W=24): push/pop, overflow,
// underflow, replace, commit/flush restore and mid-operation reset.
module tb_aq_ifu_ras_stack;

    localparam int DEPTH = 8;
    localparam int PC_W  = 24;

    logic            forever_cpuclk;
    logic            cpurst_b;
    logic            cp0_yy_clk_en;
    logic            cp0_ifu_icg_en;
    logic            pad_yy_icg_scan_en;
    logic            ras_push;
    logic [PC_W-1:0] ras_push_pc;
    logic            ras_pop;
    logic            ras_cmt_push;
    logic            ras_cmt_pop;
    logic            ras_flush;
    logic [PC_W-1:0] ras_top_pc;
    logic            ras_top_vld;
    logic            ras_full;

    int n_vec;
    int n_bad;

    aq_ifu_ras_stack #(
        .DEPTH (DEPTH),
        .PC_W  (PC_W)
    ) dut (
        .forever_cpuclk     (forever_cpuclk),
        .cpurst_b           (cpurst_b),
        .cp0_yy_clk_en      (cp0_yy_clk_en),
        .cp0_ifu_icg_en     (cp0_ifu_icg_en),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .ras_push           (ras_push),
        .ras_push_pc        (ras_push_pc),
        .ras_pop            (ras_pop),
        .ras_cmt_push       (ras_cmt_push),
        .ras_cmt_pop        (ras_cmt_pop),
        .ras_flush          (ras_flush),
        .ras_top_pc         (ras_top_pc),
        .ras_top_vld        (ras_top_vld),
        .ras_full           (ras_full)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ras_push     = 1'b0;
        ras_push_pc  = '0;
        ras_pop      = 1'b0;
        ras_cmt_push = 1'b0;
        ras_cmt_pop  = 1'b0;
        ras_flush    = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge; return 1 ns after the
    // rising edge with inputs idle, so outputs reflect the op just applied.
    task automatic step(input logic push, input logic [PC_W-1:0] pc, input logic pop,
                        input logic cpush, input logic cpop, input logic flush);
        @(negedge forever_cpuclk);
        ras_push     = push;
        ras_push_pc  = pc;
        ras_pop      = pop;
        ras_cmt_push = cpush;
        ras_cmt_pop  = cpop;
        ras_flush    = flush;
        @(posedge forever_cpuclk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        @(negedge forever_cpuclk);
        cpurst_b = 1'b0;
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        #1;
    endtask

    task automatic check_out(input string tag, input logic [PC_W-1:0] pc,
                             input logic vld, input logic full);
        check({tag, ".pc"},   32'(ras_top_pc),  32'(pc));
        check({tag, ".vld"},  32'(ras_top_vld), 32'(vld));
        check({tag, ".full"}, 32'(ras_full),    32'(full));
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        cp0_yy_clk_en      = 1'b1;
        cp0_ifu_icg_en     = 1'b0;
        pad_yy_icg_scan_en = 1'b0;
        clear_inputs();
        cpurst_b = 1'b0;
        #12;
        cpurst_b = 1'b1;
        #1;

        // Reset state
        check_out("rst", 24'h0, 1'b0, 1'b0);
        check("rst.spec_cnt", 32'(dut.r_spec_cnt), 32'd0);
        check("rst.spec_tp",  32'(dut.r_spec_tp),  32'd7);

        // Basic push/pop
        step(1, 24'h000100, 0, 0, 0, 0);
        check_out("push1", 24'h000100, 1'b1, 1'b0);
        step(1, 24'h000200, 0, 0, 0, 0);
        check_out("push2", 24'h000200, 1'b1, 1'b0);
        step(0, 24'h0, 1, 0, 0, 0);
        check_out("pop1", 24'h000100, 1'b1, 1'b0);
        step(0, 24'h0, 1, 0, 0, 0);
        check("pop2.vld", 32'(ras_top_vld), 32'd0);
        check("pop2.tp",  32'(dut.r_spec_tp), 32'd7);

        // Overflow: 9 pushes into 8 entries, value 9 overwrites entry 0
        for (int i = 1; i <= 9; i++) begin
            step(1, PC_W'(i), 0, 0, 0, 0);
            if (i == 7) check_out("ovf7", 24'd7, 1'b1, 1'b0);
            if (i == 8) check_out("ovf8", 24'd8, 1'b1, 1'b1);
        end
        check_out("ovf9", 24'd9, 1'b1, 1'b1);
        check("ovf9.cnt", 32'(dut.r_spec_cnt), 32'd8);
        check("ovf9.tp",  32'(dut.r_spec_tp),  32'd0);
        for (int k = 1; k <= 7; k++) begin
            step(0, 24'h0, 1, 0, 0, 0);
            check_out($sformatf("unw%0d", k), PC_W'(9 - k), 1'b1, 1'b0);
        end
        step(0, 24'h0, 1, 0, 0, 0);
        check_out("unw8", 24'd9, 1'b0, 1'b0);
        step(0, 24'h0, 1, 0, 0, 0);
        check_out("udf", 24'd9, 1'b0, 1'b0);
        check("udf.cnt", 32'(dut.r_spec_cnt), 32'd0);
        check("udf.tp",  32'(dut.r_spec_tp),  32'd0);

        // Push+pop replace at cnt 2, then at cnt 0
        do_reset();
        step(1, 24'h000111, 0, 0, 0, 0);
        step(1, 24'h000222, 0, 0, 0, 0);
        step(1, 24'h000ABC, 1, 0, 0, 0);
        check_out("repl", 24'h000ABC, 1'b1, 1'b0);
        check("repl.cnt", 32'(dut.r_spec_cnt), 32'd2);
        step(0, 24'h0, 1, 0, 0, 0);
        check_out("repl.pop", 24'h000111, 1'b1, 1'b0);
        do_reset();
        step(1, 24'h000ABC, 1, 0, 0, 0);
        check_out("repl0", 24'h000ABC, 1'b1, 1'b0);
        check("repl0.cnt", 32'(dut.r_spec_cnt), 32'd1);

        // Commit then flush restore
        do_reset();
        step(1, 24'h000010, 0, 1, 0, 0);
        step(1, 24'h000020, 0, 1, 0, 0);
        step(1, 24'h000030, 0, 0, 0, 0);
        step(1, 24'h000040, 0, 0, 0, 0);
        step(1, 24'h000050, 0, 0, 0, 0);
        check("spec5.cnt", 32'(dut.r_spec_cnt), 32'd5);
        check("cmt2.cnt",  32'(dut.r_cmt_cnt),  32'd2);
        step(0, 24'h0, 0, 0, 0, 1);
        check_out("flush", 24'h000020, 1'b1, 1'b0);
        check("flush.cnt",  32'(dut.r_spec_cnt), 32'd2);
        check("flush.tp",   32'(dut.r_spec_tp),  32'd1);
        check("flush.ctp",  32'(dut.r_cmt_tp),   32'd1);
        step(1, 24'h000060, 0, 0, 0, 0);
        check_out("push6", 24'h000060, 1'b1, 1'b0);
        step(0, 24'h0, 0, 0, 1, 1);
        check_out("flush.cpop", 24'h000010, 1'b1, 1'b0);
        check("flush.cpop.cnt", 32'(dut.r_spec_cnt), 32'd1);
        check("flush.cpop.tp",  32'(dut.r_spec_tp),  32'd0);

        // Flush beats a same-cycle speculative push (no entry write either)
        step(1, 24'h000077, 0, 0, 0, 1);
        check_out("flush.push", 24'h000010, 1'b1, 1'b0);
        check("flush.push.cnt", 32'(dut.r_spec_cnt), 32'd1);
        step(0, 24'h0, 0, 0, 0, 0);
        step(1, 24'h000033, 1, 0, 0, 0);
        step(1, 24'h000044, 0, 0, 0, 0);
        check("flush.push.nowr", 32'(ras_top_pc), 32'h000044);
        step(0, 24'h0, 1, 0, 0, 0);
        check("flush.push.e0", 32'(ras_top_pc), 32'h000033);

        // Reset asserted while a push is in progress
        @(negedge forever_cpuclk);
        ras_push    = 1'b1;
        ras_push_pc = 24'h000088;
        ras_cmt_push = 1'b1;
        #2;
        cpurst_b = 1'b0;
        @(posedge forever_cpuclk);
        #1;
        clear_inputs();
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        #1;
        check_out("midrst", 24'h0, 1'b0, 1'b0);
        check("midrst.cnt",  32'(dut.r_spec_cnt), 32'd0);
        check("midrst.ccnt", 32'(dut.r_cmt_cnt),  32'd0);
        step(1, 24'h000099, 0, 0, 0, 0);
        check_out("postrst", 24'h000099, 1'b1, 1'b0);
        check("postrst.tp", 32'(dut.r_spec_tp), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
